// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if
// Bundles the RegFile write-port arbitration signals.
//   wb_*          pipeline writeback request (no backpressure)
//   lu_*          long-latency result offer, valid/ready handshake
//   rf_*          single RegFile write port
//   stall_req     arbiter asks the pipeline to hold wb_valid low
//   pending_mask  destinations still buffered in the arbiter FIFO
//   proto_err     sticky flag: wb_valid seen while stall_req was high
// master: pipeline / long-latency side. slave: the arbiter.
interface rf_write_arbiter_if #(
  parameter int XLEN = 32
);
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            lu_valid;
  logic            lu_ready;
  logic [4:0]      lu_rd;
  logic [XLEN-1:0] lu_data;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic            stall_req;
  logic [31:0]     pending_mask;
  logic            proto_err;

  modport master (
    output wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
    input  lu_ready, rf_we, rf_rd, rf_wdata, stall_req, pending_mask, proto_err
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
    output lu_ready, rf_we, rf_rd, rf_wdata, stall_req, pending_mask, proto_err
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Shares the RegFile write port between pipeline writeback (always first)
// and a long-latency unit whose results wait in a small FIFO and drain into
// idle writeback slots. A starvation counter raises stall_req when the FIFO
// head has waited STARVE_LIMIT cycles.
// Ports:
//   clk    system clock, posedge
//   rst_n  asynchronous active-low reset
//   bus    rf_write_arbiter_if.slave (wb_*, lu_*, rf_*, stall_req,
//          pending_mask, proto_err)
// Optional feature: define RF_ARB_BYPASS_EN to let an lu result write the
// RegFile in its accept cycle when the FIFO is empty and wb is idle.
module rf_write_arbiter #(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rf_write_arbiter_if.slave    bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [4:0]      rd_q   [FIFO_DEPTH];
  logic [XLEN-1:0] data_q [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      starve_q, starve_d;
  logic            proto_err_q, proto_err_d;

  logic empty, full, stall;
  logic wb_grant, head_grant, byp_grant, push, pop, lu_ready;
  logic [31:0] pend;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign stall = !empty && (starve_q == LIMIT);

  always_comb begin
    wb_grant   = bus.wb_valid && !stall;
    head_grant = !wb_grant && !empty;
`ifdef RF_ARB_BYPASS_EN
    byp_grant  = !wb_grant && empty && bus.lu_valid;
`else
    byp_grant  = 1'b0;
`endif
    // Gated by rst_n so every output reads 0 while reset is held.
    lu_ready = rst_n && !full;
    push     = bus.lu_valid && lu_ready && !byp_grant;
    pop      = head_grant;
  end

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_rd    = '0;
    bus.rf_wdata = '0;
    if (rst_n) begin
      if (wb_grant) begin
        bus.rf_we    = (bus.wb_rd != 5'd0);
        bus.rf_rd    = bus.wb_rd;
        bus.rf_wdata = bus.wb_data;
      end else if (head_grant) begin
        bus.rf_we    = (rd_q[rd_ptr_q] != 5'd0);
        bus.rf_rd    = rd_q[rd_ptr_q];
        bus.rf_wdata = data_q[rd_ptr_q];
      end else if (byp_grant) begin
        bus.rf_we    = (bus.lu_rd != 5'd0);
        bus.rf_rd    = bus.lu_rd;
        bus.rf_wdata = bus.lu_data;
      end
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_comb begin
    pend = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (CW'(i) < count_q)
        pend = pend | (32'd1 << rd_q[rd_ptr_q + PW'(i)]);
    end
    pend[0] = 1'b0;
  end

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    starve_d = starve_q;
    if (empty || head_grant)   starve_d = 4'd0;
    else if (starve_q != LIMIT) starve_d = starve_q + 4'd1;

    proto_err_d = proto_err_q || (bus.wb_valid && stall);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      proto_err_q <= proto_err_d;
      if (push) begin
        rd_q[wr_ptr_q]   <= bus.lu_rd;
        data_q[wr_ptr_q] <= bus.lu_data;
      end
    end
  end

  assign bus.lu_ready     = lu_ready;
  assign bus.stall_req    = stall;
  assign bus.pending_mask = pend;
  assign bus.proto_err    = proto_err_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter
// Directed bench for rf_write_arbiter in its default build (bypass off),
// FIFO_DEPTH=2, STARVE_LIMIT=4. Inputs change just after negedge; outputs
// are checked 1 ns later, before the next posedge commits the cycle.
module tb_rf_write_arbiter;
  logic clk;
  logic rst_n;
  int n_cmp = 0;
  int n_err = 0;

  rf_write_arbiter_if #(.XLEN(32)) bus ();

  rf_write_arbiter #(.XLEN(32), .FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    bus.wb_valid = wv; bus.wb_rd = wrd; bus.wb_data = wd;
    bus.lu_valid = lv; bus.lu_rd = lrd; bus.lu_data = ld;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 32'hA5A5A5A5, 1'b1, 5'd6, 32'h1);
    #2;
    chk("rst_rf_we",     bus.rf_we, 0);
    chk("rst_rf_wdata",  bus.rf_wdata, 0);
    chk("rst_lu_ready",  bus.lu_ready, 0);
    chk("rst_stall",     bus.stall_req, 0);
    chk("rst_mask",      bus.pending_mask, 0);
    chk("rst_proto",     bus.proto_err, 0);

    next_cycle(); rst_n = 1'b1; drive(0, 0, 0, 0, 0, 0); #1;
    chk("rel_lu_ready",  bus.lu_ready, 1);
    chk("rel_rf_we",     bus.rf_we, 0);

    // pipeline writeback with empty FIFO
    next_cycle(); drive(1, 5'd5, 32'hA5A5A5A5, 0, 0, 0); #1;
    chk("wb_we",    bus.rf_we, 1);
    chk("wb_rd",    bus.rf_rd, 5);
    chk("wb_data",  bus.rf_wdata, 32'hA5A5A5A5);
    chk("wb_stall", bus.stall_req, 0);

    // lu push, written the following idle cycle
    next_cycle(); drive(0, 0, 0, 1, 5'd7, 32'h1234); #1;
    chk("push_we",    bus.rf_we, 0);
    chk("push_ready", bus.lu_ready, 1);
    next_cycle(); drive(0, 0, 0, 0, 0, 0); #1;
    chk("pop_mask", bus.pending_mask, 32'h80);
    chk("pop_we",   bus.rf_we, 1);
    chk("pop_rd",   bus.rf_rd, 7);
    chk("pop_data", bus.rf_wdata, 32'h1234);
    next_cycle(); #1;
    chk("after_mask", bus.pending_mask, 0);
    chk("after_we",   bus.rf_we, 0);
    chk("after_rd",   bus.rf_rd, 0);

    // fill FIFO while wb holds the port, then starve to stall
    next_cycle(); drive(1, 5'd3, 32'h1, 1, 5'd9, 32'h99); #1;
    chk("f1_rd", bus.rf_rd, 3);
    next_cycle(); drive(1, 5'd3, 32'h1, 1, 5'd10, 32'hAA); #1;
    chk("f2_rd",    bus.rf_rd, 3);
    chk("f2_mask",  bus.pending_mask, 32'h200);
    chk("f2_ready", bus.lu_ready, 1);
    next_cycle(); drive(1, 5'd3, 32'h1, 0, 0, 0); #1;
    chk("full_ready", bus.lu_ready, 0);
    chk("full_mask",  bus.pending_mask, 32'h600);
    chk("f3_stall",   bus.stall_req, 0);
    next_cycle(); #1;
    next_cycle(); #1;
    chk("f5_stall", bus.stall_req, 0);
    next_cycle(); drive(0, 0, 0, 0, 0, 0); #1;
    chk("f6_stall", bus.stall_req, 1);
    chk("f6_we",    bus.rf_we, 1);
    chk("f6_rd",    bus.rf_rd, 9);
    next_cycle(); #1;
    chk("f7_stall", bus.stall_req, 0);
    chk("f7_rd",    bus.rf_rd, 10);
    chk("f7_data",  bus.rf_wdata, 32'hAA);
    next_cycle(); #1;
    chk("f8_mask",  bus.pending_mask, 0);
    chk("f8_ready", bus.lu_ready, 1);
    chk("f8_proto", bus.proto_err, 0);

    // protocol violation: wb_valid held through stall_req
    next_cycle(); drive(1, 5'd4, 32'h44, 1, 5'd12, 32'hC); #1;
    next_cycle(); drive(1, 5'd4, 32'h44, 1, 5'd13, 32'hD); #1;
    next_cycle(); drive(1, 5'd4, 32'h44, 0, 0, 0); #1;
    next_cycle(); #1;
    next_cycle(); #1;
    chk("p5_stall", bus.stall_req, 0);
    next_cycle(); #1;
    chk("p6_stall", bus.stall_req, 1);
    chk("p6_we",    bus.rf_we, 1);
    chk("p6_rd",    bus.rf_rd, 12);
    chk("p6_data",  bus.rf_wdata, 32'hC);
    chk("p6_proto", bus.proto_err, 0);
    next_cycle(); drive(0, 0, 0, 0, 0, 0); #1;
    chk("p7_proto", bus.proto_err, 1);
    chk("p7_stall", bus.stall_req, 0);
    chk("p7_rd",    bus.rf_rd, 13);
    next_cycle(); #1;
    chk("p8_proto", bus.proto_err, 1);
    chk("p8_mask",  bus.pending_mask, 0);

    // rd=0 entry: popped but never written
    next_cycle(); drive(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF); #1;
    chk("z_push_we", bus.rf_we, 0);
    next_cycle(); drive(0, 0, 0, 0, 0, 0); #1;
    chk("z_pop_we",   bus.rf_we, 0);
    chk("z_pop_data", bus.rf_wdata, 32'hFFFFFFFF);
    chk("z_mask",     bus.pending_mask, 0);
    next_cycle(); #1;
    chk("z_empty_data", bus.rf_wdata, 0);
    chk("z_proto",      bus.proto_err, 1);

    // reset with two entries buffered
    next_cycle(); drive(1, 5'd0, 32'h0, 1, 5'd20, 32'h20); #1;
    next_cycle(); drive(1, 5'd0, 32'h0, 1, 5'd21, 32'h21); #1;
    next_cycle(); drive(1, 5'd2, 32'h22, 0, 0, 0); #1;
    chk("s3_mask", bus.pending_mask, 32'h300000);
    chk("s3_rd",   bus.rf_rd, 2);
    rst_n = 1'b0; #1;
    chk("mid_rst_we",    bus.rf_we, 0);
    chk("mid_rst_rd",    bus.rf_rd, 0);
    chk("mid_rst_ready", bus.lu_ready, 0);
    chk("mid_rst_mask",  bus.pending_mask, 0);
    chk("mid_rst_proto", bus.proto_err, 0);
    chk("mid_rst_stall", bus.stall_req, 0);
    next_cycle(); rst_n = 1'b1; drive(0, 0, 0, 0, 0, 0); #1;
    chk("post_we",    bus.rf_we, 0);
    chk("post_mask",  bus.pending_mask, 0);
    chk("post_ready", bus.lu_ready, 1);
    next_cycle(); #1;
    chk("post2_we",   bus.rf_we, 0);
    chk("post2_data", bus.rf_wdata, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
